// File: rtl/mpadd_pkg.sv
// mpadd_pkg: shared FSM states and sizing constants for the mpadd256 scheduler.
package mpadd_pkg;
    typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, DONE} state_t;
    localparam int MPADD_WIDTH          = 256;
    localparam int MPADD_TIMEOUT_CYCLES = 1024;
endpackage

// File: rtl/mpadd_sched_arb.sv
// rr_arbiter: combinational round-robin picker; first set req bit at or above ptr, wrapping.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IW-1:0]      ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IW-1:0]      idx_o
);
    int j;
    // Scan from farthest to nearest so the closest hit to ptr wins.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        j     = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            j = (int'(ptr_i) + k) % NUM_REQ;
            if (req_i[IW'(j)]) begin
                gnt_o          = '0;
                gnt_o[IW'(j)]  = 1'b1;
                idx_o          = IW'(j);
            end
        end
    end
endmodule

// File: rtl/mpadd_sched.sv
// mpadd_sched: round-robin scheduler sharing one mpadd256 adder among NUM_REQ requesters.
// Define MPADD_SCHED_TIMEOUT_EN to add a WAIT watchdog and the per-requester err output.
module mpadd_sched
    import mpadd_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = MPADD_WIDTH
`ifdef MPADD_SCHED_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = MPADD_TIMEOUT_CYCLES
`endif
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic [NUM_REQ-1:0]       gnt,
    output logic [NUM_REQ-1:0]       done,
`ifdef MPADD_SCHED_TIMEOUT_EN
    output logic [NUM_REQ-1:0]       err,
`endif
    output logic [WIDTH:0]           res,
    output logic                     busy,
    output logic [WIDTH-1:0]         add_a,
    output logic [WIDTH-1:0]         add_b,
    output logic                     add_write,
    output logic                     add_start,
    input  logic                     add_ready,
    input  logic [WIDTH:0]           add_s
);
    localparam int IW = $clog2(NUM_REQ);

    state_t             state_q, state_d;
    logic [IW-1:0]      ptr_q, ptr_d, win_q, win_d, arb_idx;
    logic [NUM_REQ-1:0] gnt_q, gnt_d, arb_gnt;
    logic [WIDTH:0]     res_q, res_d;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .IW(IW)) u_arb (
        .req_i(req),
        .ptr_i(ptr_q),
        .gnt_o(arb_gnt),
        .idx_o(arb_idx)
    );

`ifdef MPADD_SCHED_TIMEOUT_EN
    logic [15:0] cnt_q;
    logic        to_q;
    logic        hit;
    assign hit = cnt_q == 16'(TIMEOUT_CYCLES);
    // to_q is set only on the timed-out WAIT->DONE edge, so it is high exactly in that DONE.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_q <= '0;
            to_q  <= 1'b0;
        end else begin
            cnt_q <= state_q == START ? '0 : state_q == WAIT ? cnt_q + 16'd1 : cnt_q;
            to_q  <= state_q == WAIT && !add_ready && hit;
        end
    end
    assign err = done & {NUM_REQ{to_q}};
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        gnt_d   = gnt_q;
        res_d   = res_q;
        unique case (state_q)
            IDLE: if (|req) begin
                state_d = LOAD;
                gnt_d   = arb_gnt;
                win_d   = arb_idx;
                ptr_d   = arb_idx == IW'(NUM_REQ - 1) ? '0 : arb_idx + 1'b1;
            end
            LOAD:  state_d = START;
            START: state_d = WAIT;
            WAIT: if (add_ready) begin
                state_d = DONE;
                res_d   = add_s;
            end
`ifdef MPADD_SCHED_TIMEOUT_EN
            else if (hit) begin
                state_d = DONE;
                res_d   = '0;
            end
`endif
            DONE: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            win_q   <= '0;
            gnt_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            gnt_q   <= gnt_d;
            res_q   <= res_d;
        end
    end

    assign busy      = state_q != IDLE;
    assign gnt       = gnt_q;
    assign done      = state_q == DONE ? gnt_q : '0;
    assign res       = res_q;
    assign add_write = state_q == LOAD;
    assign add_start = state_q == START;
    assign add_a     = |gnt_q ? req_a[int'(win_q)*WIDTH +: WIDTH] : '0;
    assign add_b     = |gnt_q ? req_b[int'(win_q)*WIDTH +: WIDTH] : '0;
endmodule

// File: tb/tb_mpadd_sched.sv
// tb_mpadd_sched: directed self-checking bench for mpadd_sched with a 3-cycle adder model.
module tb_mpadd_sched;
    localparam logic [255:0] ONES = '1;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic [3:0]    req;
    logic [1023:0] req_a, req_b;
    logic [3:0]    gnt, done;
    logic [256:0]  res;
    logic          busy;
    logic [255:0]  add_a, add_b;
    logic          add_write, add_start, add_ready;
    logic [256:0]  add_s;
`ifdef MPADD_SCHED_TIMEOUT_EN
    logic [3:0]    err;
`endif
    int n_pass = 0, n_fail = 0, n_total = 0;

    mpadd_sched #(
        .NUM_REQ(4), .WIDTH(256)
`ifdef MPADD_SCHED_TIMEOUT_EN
        , .TIMEOUT_CYCLES(8)
`endif
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .req(req), .req_a(req_a), .req_b(req_b),
        .gnt(gnt), .done(done),
`ifdef MPADD_SCHED_TIMEOUT_EN
        .err(err),
`endif
        .res(res), .busy(busy), .add_a(add_a), .add_b(add_b),
        .add_write(add_write), .add_start(add_start), .add_ready(add_ready), .add_s(add_s)
    );

    always #5 CLK = ~CLK;

    // Adder model: latch on write (clears ready), raise ready 3 cycles after start unless stalled.
    logic [255:0] ma, mb;
    int           mcnt;
    logic         stall = 1'b0;
    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            add_ready <= 1'b0;
            add_s     <= '0;
            mcnt      <= 0;
        end else if (add_write) begin
            ma        <= add_a;
            mb        <= add_b;
            add_ready <= 1'b0;
        end else if (add_start) begin
            mcnt <= 3;
        end else if (mcnt != 0 && !stall) begin
            mcnt <= mcnt - 1;
            if (mcnt == 1) begin
                add_ready <= 1'b1;
                add_s     <= {1'b0, ma} + {1'b0, mb};
            end
        end
    end

    task automatic chk(input string tag, input logic [256:0] obs, input logic [256:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_ops(input int i, input logic [255:0] a, input logic [255:0] b);
        req_a[i*256 +: 256] = a;
        req_b[i*256 +: 256] = b;
    endtask

    task automatic wait_done(input string tag, input logic [3:0] ed, input logic [256:0] er);
        int n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (done == 4'b0 && n < 50);
        chk({tag, "_done"}, 257'(done), 257'(ed));
        chk({tag, "_res"}, res, er);
        chk({tag, "_gnt"}, 257'(gnt), 257'(ed));
        req = req & ~ed;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        req = '0; req_a = '0; req_b = '0;
        repeat (2) @(negedge CLK);
        chk("rst_gnt", 257'(gnt), 257'(0));
        chk("rst_done", 257'(done), 257'(0));
        chk("rst_res", res, 257'(0));
        chk("rst_busy", 257'(busy), 257'(0));
        chk("rst_write", 257'(add_write), 257'(0));
        chk("rst_start", 257'(add_start), 257'(0));
        RST_N = 1'b1;
        @(negedge CLK);

        set_ops(0, 256'h1, ONES);
        req = 4'b0001;
        @(negedge CLK);
        chk("single_write", 257'(add_write), 257'(1));
        chk("single_gnt", 257'(gnt), 257'(4'b0001));
        chk("single_add_a", 257'(add_a), 257'(1));
        chk("single_add_b", 257'(add_b), 257'(ONES));
        @(negedge CLK);
        chk("single_start", 257'(add_start), 257'(1));
        chk("single_write_low", 257'(add_write), 257'(0));
        wait_done("single", 4'b0001, {1'b1, 256'h0});

        set_ops(3, 256'h1234, 256'h4321);
        @(negedge CLK);
        req = 4'b1000;
        wait_done("r3", 4'b1000, 257'h5555);
        set_ops(0, 256'h10, 256'h20);
        @(negedge CLK);
        req = 4'b1001;
        wait_done("wrap0", 4'b0001, 257'h30);
        wait_done("wrap3", 4'b1000, 257'h5555);

        set_ops(1, 256'h100, 256'h5);
        set_ops(2, ONES, 256'h2);
        @(negedge CLK);
        req = 4'b1111;
        wait_done("all0", 4'b0001, 257'h30);
        wait_done("all1", 4'b0010, 257'h105);
        wait_done("all2", 4'b0100, {1'b1, 256'h1});
        wait_done("all3", 4'b1000, 257'h5555);

        set_ops(2, 256'hAAAA, 256'h5555);
        @(negedge CLK);
        req = 4'b0100;
        repeat (3) @(negedge CLK);
        chk("drop_gnt_wait", 257'(gnt), 257'(4'b0100));
        req = 4'b0000;
        wait_done("drop", 4'b0100, 257'hFFFF);
        repeat (4) @(negedge CLK);
        chk("drop_no_regnt", 257'(gnt), 257'(0));
        chk("drop_idle", 257'(busy), 257'(0));

        req = 4'b0010;
        repeat (3) @(negedge CLK);
        RST_N = 1'b0;
        req = 4'b0000;
        #1;
        chk("mrst_gnt", 257'(gnt), 257'(0));
        chk("mrst_busy", 257'(busy), 257'(0));
        chk("mrst_start", 257'(add_start), 257'(0));
        chk("mrst_res", res, 257'(0));
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        req = 4'b0110;
        @(negedge CLK);
        chk("mrst_ptr0", 257'(gnt), 257'(4'b0010));
        wait_done("mrst", 4'b0010, 257'h105);
        req = 4'b0000;

`ifdef MPADD_SCHED_TIMEOUT_EN
        stall = 1'b1;
        @(negedge CLK);
        req = 4'b0001;
        repeat (11) @(negedge CLK);
        chk("to_early", 257'(done), 257'(0));
        @(negedge CLK);
        chk("to_done", 257'(done), 257'(4'b0001));
        chk("to_err", 257'(err), 257'(4'b0001));
        chk("to_res", res, 257'(0));
        req = 4'b0000;
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
